// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic RV64 requests into 32-bit words and streams them to imem
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [3:0]  i_in_op,
    input  logic [4:0]  i_in_rd,
    input  logic [4:0]  i_in_rs1,
    input  logic [4:0]  i_in_rs2,
    input  logic [63:0] i_in_imm,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [63:0] o_out_addr,
    output logic        o_err_valid,
    output logic [1:0]  o_err_code,
    output logic        o_done
);
    logic               r_out_valid;
    logic [31:0]        r_out_instr;
    logic [63:0]        r_addr;
    logic [31:0]        r_count;
    logic               r_done;
    logic               r_err_valid;
    logic [1:0]         r_err_code;
    logic signed [63:0] w_imm;
    logic               w_is_i;
    logic               w_is_b;
    logic               w_i_ok;
    logic               w_b_ok;
    logic [1:0]         w_err;
    logic [31:0]        w_word;
    logic               w_accept;
    logic               w_fire;

    assign w_imm  = i_in_imm;
    assign w_is_i = (i_in_op >= 4'd4) && (i_in_op <= 4'd8);
    assign w_is_b = (i_in_op >= 4'd9) && (i_in_op <= 4'd11);
    // full 64-bit signed compares so large immediates cannot alias into range
    assign w_i_ok = (w_imm >= -64'sd2048) && (w_imm <= 64'sd2047);
    assign w_b_ok = (w_imm >= -64'sd4096) && (w_imm <= 64'sd4094);

    assign o_in_ready = rst_n && !r_done && !i_clear && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_fire     = r_out_valid && i_out_ready && !i_clear;

    // rejection code, highest priority first: illegal op, range, odd branch offset
    always_comb begin
        w_err = (i_in_op > 4'd11) ? 2'b01 :
                ((w_is_i && !w_i_ok) || (w_is_b && !w_b_ok)) ? 2'b10 :
                (w_is_b && i_in_imm[0]) ? 2'b11 : 2'b00;
    end

    // field packing per instruction format
    always_comb begin
        w_word = 32'h0;
        case (i_in_op)
            4'd0:  w_word = {7'b0000000, i_in_rs2, i_in_rs1, 3'b000, i_in_rd, 7'b0110011};
            4'd1:  w_word = {7'b0100000, i_in_rs2, i_in_rs1, 3'b000, i_in_rd, 7'b0110011};
            4'd2:  w_word = {7'b0000000, i_in_rs2, i_in_rs1, 3'b111, i_in_rd, 7'b0110011};
            4'd3:  w_word = {7'b0000000, i_in_rs2, i_in_rs1, 3'b110, i_in_rd, 7'b0110011};
            4'd4:  w_word = {i_in_imm[11:0], i_in_rs1, 3'b000, i_in_rd, 7'b0010011};
            4'd5:  w_word = {i_in_imm[11:0], i_in_rs1, 3'b110, i_in_rd, 7'b0010011};
            4'd6:  w_word = {i_in_imm[11:0], i_in_rs1, 3'b100, i_in_rd, 7'b0010011};
            4'd7:  w_word = {i_in_imm[11:0], i_in_rs1, 3'b011, i_in_rd, 7'b0000011};
            4'd8:  w_word = {i_in_imm[11:5], i_in_rs2, i_in_rs1, 3'b011, i_in_imm[4:0], 7'b0100011};
            4'd9:  w_word = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, 3'b000,
                             i_in_imm[4:1], i_in_imm[11], 7'b1100011};
            4'd10: w_word = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, 3'b001,
                             i_in_imm[4:1], i_in_imm[11], 7'b1100011};
            4'd11: w_word = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, 3'b101,
                             i_in_imm[4:1], i_in_imm[11], 7'b1100011};
            default: w_word = 32'h0;
        endcase
    end

    // one-entry output register, address/count tracking and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_addr      <= BASE_ADDR;
            r_count     <= 32'd0;
            r_done      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'b00;
        end else if (i_clear) begin
            r_out_valid <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_count     <= 32'd0;
            r_done      <= 1'b0;
            r_err_valid <= 1'b0;
        end else begin
            r_err_valid <= w_accept && (w_err != 2'b00);
            if (w_accept && (w_err != 2'b00))
                r_err_code <= w_err;
            if (w_accept && (w_err == 2'b00))
                r_out_instr <= w_word;
            r_out_valid <= (w_accept && (w_err == 2'b00)) || (r_out_valid && !w_fire);
            if (w_fire) begin
                r_addr  <= r_addr + 64'd4;
                r_count <= r_count + 32'd1;
                if (r_count + 32'd1 == MEM_WORDS)
                    r_done <= 1'b1;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_instr = r_out_instr;
    assign o_out_addr  = r_addr;
    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;
    assign o_done      = r_done;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [3:0]  i_in_op = 4'd0;
    logic [4:0]  i_in_rd = 5'd0;
    logic [4:0]  i_in_rs1 = 5'd0;
    logic [4:0]  i_in_rs2 = 5'd0;
    logic [63:0] i_in_imm = 64'd0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [31:0] o_out_instr;
    logic [63:0] o_out_addr;
    logic        o_err_valid;
    logic [1:0]  o_err_code;
    logic        o_done;

    logic [31:0] q[$];
    logic [63:0] m_addr = 64'd0;
    int          errors = 0;
    int          checks = 0;

    instr_encoder #(.BASE_ADDR(64'h0), .MEM_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_op(i_in_op), .i_in_rd(i_in_rd), .i_in_rs1(i_in_rs1), .i_in_rs2(i_in_rs2),
        .i_in_imm(i_in_imm),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_instr(o_out_instr), .o_out_addr(o_out_addr),
        .o_err_valid(o_err_valid), .o_err_code(o_err_code), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm);
        i_in_valid = 1'b1;
        i_in_op    = op;
        i_in_rd    = rd;
        i_in_rs1   = rs1;
        i_in_rs2   = rs2;
        i_in_imm   = imm;
    endtask

    // one clock: score any output fire, queue any legal accept, then step past the edge
    task automatic tick(input logic [31:0] w, input bit legal);
        logic [31:0] e;
        #1;
        if (o_out_valid && i_out_ready && !i_clear) begin
            chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_instr", 64'(o_out_instr), 64'(e));
                chk("out_addr", o_out_addr, m_addr);
            end
            m_addr += 64'd4;
        end
        if (i_in_valid && o_in_ready && legal)
            q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        i_in_valid = 1'b0;
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        q.delete();
        m_addr = 64'd0;
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_in_ready", 64'(o_in_ready), 64'd0);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_out_instr", 64'(o_out_instr), 64'd0);
        chk("rst_out_addr", o_out_addr, 64'd0);
        chk("rst_err_valid", 64'(o_err_valid), 64'd0);
        chk("rst_err_code", 64'(o_err_code), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single ADD
        i_out_ready = 1'b1;
        req(4'd0, 5'd3, 5'd1, 5'd2, 64'd0);
        tick(32'h002081B3, 1'b1);
        i_in_valid = 1'b0;
        chk("t1_out_valid", 64'(o_out_valid), 64'd1);
        tick(32'h0, 1'b0);
        chk("t1_drained", 64'(o_out_valid), 64'd0);
        do_clear();

        // 2: back-to-back stream with ready held high
        req(4'd4, 5'd2, 5'd1, 5'd0, 64'd5);
        #1 chk("t2_ready0", 64'(o_in_ready), 64'd1);
        tick(32'h00508113, 1'b1);
        req(4'd8, 5'd0, 5'd3, 5'd2, 64'd4);
        chk("t2_ready1", 64'(o_in_ready), 64'd1);
        tick(32'h0021B223, 1'b1);
        req(4'd9, 5'd0, 5'd1, 5'd2, 64'd8);
        chk("t2_ready2", 64'(o_in_ready), 64'd1);
        tick(32'h00208463, 1'b1);
        i_in_valid = 1'b0;
        tick(32'h0, 1'b0);
        chk("t2_addr_after", o_out_addr, 64'd12);
        do_clear();

        // 3: LD stalled by out_ready=0 for three cycles
        i_out_ready = 1'b0;
        req(4'd7, 5'd4, 5'd3, 5'd0, -64'sd8);
        tick(32'hFF81B203, 1'b1);
        i_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 64'(o_out_valid), 64'd1);
            chk("t3_hold_instr", 64'(o_out_instr), 64'hFF81B203);
            chk("t3_hold_ready", 64'(o_in_ready), 64'd0);
            tick(32'h0, 1'b0);
        end
        i_out_ready = 1'b1;
        #1 chk("t3_ready_release", 64'(o_in_ready), 64'd1);
        tick(32'h0, 1'b0);

        // 4: rejected requests and immediate boundaries
        req(4'd4, 5'd1, 5'd1, 5'd0, 64'd2048);
        tick(32'h0, 1'b0);
        chk("t4_range_err", 64'(o_err_valid), 64'd1);
        chk("t4_range_code", 64'(o_err_code), 64'd2);
        chk("t4_range_noword", 64'(o_out_valid), 64'd0);
        chk("t4_range_addr", o_out_addr, m_addr);
        req(4'd14, 5'd1, 5'd1, 5'd1, 64'd0);
        tick(32'h0, 1'b0);
        chk("t4_op_err", 64'(o_err_valid), 64'd1);
        chk("t4_op_code", 64'(o_err_code), 64'd1);
        req(4'd10, 5'd0, 5'd1, 5'd2, 64'd7);
        tick(32'h0, 1'b0);
        chk("t4_odd_code", 64'(o_err_code), 64'd3);
        req(4'd9, 5'd0, 5'd1, 5'd2, 64'd4096);
        tick(32'h0, 1'b0);
        chk("t4_br_range_code", 64'(o_err_code), 64'd2);
        req(4'd4, 5'd1, 5'd1, 5'd0, 64'h0000_0001_0000_0005);
        tick(32'h0, 1'b0);
        chk("t4_wide_code", 64'(o_err_code), 64'd2);
        chk("t4_wide_noword", 64'(o_out_valid), 64'd0);
        req(4'd4, 5'd0, 5'd0, 5'd0, -64'sd2048);
        tick(32'h80000013, 1'b1);
        chk("t4_legal_noerr", 64'(o_err_valid), 64'd0);
        req(4'd11, 5'd0, 5'd0, 5'd0, 64'd4094);
        tick(32'h7E005FE3, 1'b1);
        i_in_valid = 1'b0;
        tick(32'h0, 1'b0);
        chk("t4_err_cleared", 64'(o_err_valid), 64'd0);

        // 6: async reset while a word is stalled
        i_out_ready = 1'b0;
        req(4'd0, 5'd3, 5'd1, 5'd2, 64'd0);
        tick(32'h002081B3, 1'b1);
        i_in_valid = 1'b0;
        chk("t6_pending", 64'(o_out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(o_out_valid), 64'd0);
        chk("t6_async_addr", o_out_addr, 64'd0);
        chk("t6_async_ready", 64'(o_in_ready), 64'd0);
        q.delete();
        m_addr = 64'd0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5: MEM_WORDS=4 then done, then clear restarts at base
        i_out_ready = 1'b1;
        req(4'd1, 5'd1, 5'd2, 5'd3, 64'd0);
        tick(32'h403100B3, 1'b1);
        req(4'd2, 5'd5, 5'd6, 5'd7, 64'd0);
        tick(32'h007372B3, 1'b1);
        req(4'd3, 5'd5, 5'd6, 5'd7, 64'd0);
        tick(32'h007362B3, 1'b1);
        req(4'd6, 5'd1, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(32'hFFF0C093, 1'b1);
        i_in_valid = 1'b0;
        tick(32'h0, 1'b0);
        chk("t5_done", 64'(o_done), 64'd1);
        i_in_valid = 1'b1;
        #1 chk("t5_done_ready", 64'(o_in_ready), 64'd0);
        do_clear();
        chk("t5_clear_done", 64'(o_done), 64'd0);
        chk("t5_clear_addr", o_out_addr, 64'd0);
        req(4'd5, 5'd2, 5'd0, 5'd0, 64'h7FF);
        #1 chk("t5_clear_ready", 64'(o_in_ready), 64'd1);
        tick(32'h7FF06113, 1'b1);
        i_in_valid = 1'b0;
        tick(32'h0, 1'b0);
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
